// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg
//   Shared definitions for the instruction-fetch stage: FSM state type,
//   reset vector, NOP encoding and stall-vector bit positions.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } if_state_e;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    localparam int STALL_IF = 1;
    localparam int STALL_ID = 2;

endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// if_id_reg
//   IF/ID pipeline register. Bubble has priority over load; with neither
//   control asserted the register holds its contents.
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     load_i                capture pc_i/inst_i as a valid instruction
//     bubble_i              insert a bubble (pc=0, NOP, valid=0)
//     pc_i, inst_i          PC and instruction word to load
//     id_pc_o, id_inst_o    registered PC and instruction
//     id_valid_o            1 = real instruction, 0 = bubble
module if_id_reg
    import inst_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o
);

    always_ff @(posedge clk) begin
        if (rst) begin
            id_pc_o    <= 32'h0;
            id_inst_o  <= 32'h0;
            id_valid_o <= 1'b0;
        end else if (bubble_i) begin
            id_pc_o    <= 32'h0;
            id_inst_o  <= NOP_INST;
            id_valid_o <= 1'b0;
        end else if (load_i) begin
            id_pc_o    <= pc_i;
            id_inst_o  <= inst_i;
            id_valid_o <= 1'b1;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch
//   Instruction-fetch stage. Issues single-word reads at pc_i over a
//   req/ack bus, loads {pc, word} into the IF/ID register, buffers a
//   fetched word while IF/ID is held, and drops in-flight fetches on flush.
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     pc_i                  current PC (stable while stallreq_o=1)
//     stall                 pipeline stall vector ([1]=IF/ID hold, [2]=ID hold)
//     flush_i               discard IF and IF/ID contents
//     req_o, addr_o         instruction-bus request and address
//     ack_i, rdata_i        bus completion and read data
//     stallreq_o            fetch not complete this cycle
//     id_pc_o, id_inst_o, id_valid_o   IF/ID register outputs
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic [5:0]  stall,
    input  logic        flush_i,
    output logic        req_o,
    output logic [31:0] addr_o,
    input  logic        ack_i,
    input  logic [31:0] rdata_i,
    output logic        stallreq_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o
);

    if_state_e   state_q, state_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic [31:0] drop_addr_q, drop_addr_d;

    logic        word_avail;
    logic [31:0] word_pc;
    logic [31:0] word_inst;
    logic        ifid_load;
    logic        ifid_bubble;

    // Only the IF and ID hold bits matter to this stage.
    logic unused_stall_bits;
    assign unused_stall_bits = ^{stall[5:3], stall[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            buf_pc_q    <= 32'h0;
            buf_inst_q  <= 32'h0;
            drop_addr_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            buf_pc_q    <= buf_pc_d;
            buf_inst_q  <= buf_inst_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        buf_pc_d    = buf_pc_q;
        buf_inst_d  = buf_inst_q;
        drop_addr_d = drop_addr_q;
        req_o       = 1'b0;
        addr_o      = 32'h0;
        stallreq_o  = 1'b0;
        word_avail  = 1'b0;
        word_pc     = buf_pc_q;
        word_inst   = buf_inst_q;

        case (state_q)
            S_REQ: begin
                req_o      = 1'b1;
                addr_o     = pc_i;
                stallreq_o = ~ack_i;
                if (ack_i) begin
                    word_avail = 1'b1;
                    word_pc    = pc_i;
                    word_inst  = rdata_i;
                end
                if (flush_i) begin
                    // A completed fetch is simply dropped; an incomplete one
                    // must still be drained from the bus at its old address.
                    if (!ack_i) begin
                        drop_addr_d = pc_i;
                        state_d     = S_DROP;
                    end
                end else if (ack_i && stall[STALL_IF]) begin
                    buf_pc_d   = pc_i;
                    buf_inst_d = rdata_i;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                word_avail = 1'b1;
                if (flush_i || !stall[STALL_IF]) begin
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                req_o      = 1'b1;
                addr_o     = drop_addr_q;
                stallreq_o = 1'b1;
                if (ack_i) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        if (flush_i) begin
            ifid_bubble = 1'b1;
        end else if (stall[STALL_IF]) begin
            // IF held: bubble into ID unless ID itself is held too.
            ifid_bubble = ~stall[STALL_ID];
        end else if (word_avail) begin
            ifid_load = 1'b1;
        end else begin
            ifid_bubble = 1'b1;
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ifid_load),
        .bubble_i   (ifid_bubble),
        .pc_i       (word_pc),
        .inst_i     (word_inst),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .id_valid_o (id_valid_o)
    );

endmodule
